// File: rtl/dmem_arbiter_pkg.sv
// Purpose: shared types and widths for the data-memory arbiter and its read-return path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ArbState_t (observable FSM encoding), ArbOwner_t (read-return tag owner),
//           default RAM geometry, and a state-name helper for monitors.
package ArbDefs;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 16;

  // Encoding is externally visible on ArbState: 0 = idle, 1 = CPU, 2 = host.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_HOST = 2'd2
  } ArbState_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } ArbOwner_t;

  function automatic string arb_to_string(input ArbState_t s);
    case (s)
      ARB_IDLE: return "IDLE";
      ARB_CPU:  return "CPU";
      ARB_HOST: return "HOST";
      default:  return "ILLEGAL";
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rd_return.sv
// Purpose: tags each read grant and steers the RAM read data back to the requester that issued it.
// Latency: RdValid/RdData appear the cycle after the read grant (RAM output is used directly).
// Backpressure: none; the return cannot be stalled, the requester must accept it.
// Ports: i_rd_gnt/i_rd_owner = read granted this cycle and by whom; i_mem_rd_dat = RAM output;
//        o_cpu_rd_vld/o_cpu_rd_dat and o_host_rd_vld/o_host_rd_dat = per-requester return.
module dmem_rd_return
  import ArbDefs::*;
#(
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              i_rd_gnt,
  input  ArbOwner_t         i_rd_owner,
  input  logic [DATA_W-1:0] i_mem_rd_dat,
  output logic              o_cpu_rd_vld,
  output logic [DATA_W-1:0] o_cpu_rd_dat,
  output logic              o_host_rd_vld,
  output logic [DATA_W-1:0] o_host_rd_dat
);

  logic              r_tag_vld;
  ArbOwner_t         r_tag_owner;
  logic [DATA_W-1:0] r_cpu_hold;
  logic [DATA_W-1:0] r_host_hold;
  logic              w_cpu_ret;
  logic              w_host_ret;

  assign w_cpu_ret  = r_tag_vld && (r_tag_owner == OWN_CPU);
  assign w_host_ret = r_tag_vld && (r_tag_owner == OWN_HOST);

  // Clearing the tag on reset drops any read still in flight.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_tag_vld   <= 1'b0;
      r_tag_owner <= OWN_CPU;
      r_cpu_hold  <= '0;
      r_host_hold <= '0;
    end else begin
      r_tag_vld   <= i_rd_gnt;
      r_tag_owner <= i_rd_owner;
      if (w_cpu_ret)  r_cpu_hold  <= i_mem_rd_dat;
      if (w_host_ret) r_host_hold <= i_mem_rd_dat;
    end
  end

  // The RAM word is forwarded in the return cycle; the hold register keeps it afterwards
  // so the non-owner's data never changes on the other requester's return.
  assign o_cpu_rd_vld  = w_cpu_ret;
  assign o_cpu_rd_dat  = w_cpu_ret ? i_mem_rd_dat : r_cpu_hold;
  assign o_host_rd_vld = w_host_ret;
  assign o_host_rd_dat = w_host_ret ? i_mem_rd_dat : r_host_hold;

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port sync data RAM between CPU and host.
// Latency: grant one cycle after Req is seen; read data one cycle after the read grant.
// Backpressure: requester holds Req/fields until its one-cycle Gnt; a requester granted
//               last cycle is not eligible this cycle, so a lone requester gets every other cycle.
// Ports: Cpu_*/Host_* request and return sides, Mem_* RAM side, ArbState observation.
module dmem_arbiter
  import ArbDefs::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              Cpu_Req,
  input  logic              Cpu_Wr,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  input  logic [DATA_W-1:0] Cpu_WrData,
  output logic              Cpu_Gnt,
  output logic              Cpu_RdValid,
  output logic [DATA_W-1:0] Cpu_RdData,
  input  logic              Host_Req,
  input  logic              Host_Wr,
  input  logic [ADDR_W-1:0] Host_Addr,
  input  logic [DATA_W-1:0] Host_WrData,
  output logic              Host_Gnt,
  output logic              Host_RdValid,
  output logic [DATA_W-1:0] Host_RdData,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Wr,
  output logic [DATA_W-1:0] Mem_WrData,
  input  logic [DATA_W-1:0] Mem_RdData,
  output logic [1:0]        ArbState
);

  ArbState_t         r_state;
  logic              r_last_host;   // 1 = most recent grant went to the host
  logic              w_rd_gnt;
  ArbOwner_t         w_rd_owner;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_wr;
  logic [DATA_W-1:0] w_mem_wdat;

  // Leaving a grant state never re-grants the same requester: that cycle still sees
  // its old Req, and skipping it prevents a double grant for one request.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= ARB_IDLE;
      r_last_host <= CPU_FIRST;     // pretend the host went last so CPU wins the first tie
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (Cpu_Req && (!Host_Req || r_last_host)) begin
            r_state     <= ARB_CPU;
            r_last_host <= 1'b0;
          end else if (Host_Req) begin
            r_state     <= ARB_HOST;
            r_last_host <= 1'b1;
          end
        end
        ARB_CPU: begin
          if (Host_Req) begin
            r_state     <= ARB_HOST;
            r_last_host <= 1'b1;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_HOST: begin
          if (Cpu_Req) begin
            r_state     <= ARB_CPU;
            r_last_host <= 1'b0;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    w_mem_addr = '0;
    w_mem_wr   = 1'b0;
    w_mem_wdat = '0;
    case (r_state)
      ARB_CPU: begin
        w_mem_addr = Cpu_Addr;
        w_mem_wr   = Cpu_Wr;
        w_mem_wdat = Cpu_WrData;
      end
      ARB_HOST: begin
        w_mem_addr = Host_Addr;
        w_mem_wr   = Host_Wr;
        w_mem_wdat = Host_WrData;
      end
      default: ;
    endcase
  end

  assign Cpu_Gnt    = (r_state == ARB_CPU);
  assign Host_Gnt   = (r_state == ARB_HOST);
  assign Mem_Addr   = w_mem_addr;
  assign Mem_Wr     = w_mem_wr;
  assign Mem_WrData = w_mem_wdat;
  assign ArbState   = r_state;

  assign w_rd_gnt   = (Cpu_Gnt && !Cpu_Wr) || (Host_Gnt && !Host_Wr);
  assign w_rd_owner = Host_Gnt ? OWN_HOST : OWN_CPU;

  dmem_rd_return #(
    .DATA_W(DATA_W)
  ) u_rd_return (
    .Clk           (Clk),
    .ResetN        (ResetN),
    .i_rd_gnt      (w_rd_gnt),
    .i_rd_owner    (w_rd_owner),
    .i_mem_rd_dat  (Mem_RdData),
    .o_cpu_rd_vld  (Cpu_RdValid),
    .o_cpu_rd_dat  (Cpu_RdData),
    .o_host_rd_vld (Host_RdValid),
    .o_host_rd_dat (Host_RdData)
  );

endmodule
